// File: rtl/mfcc_pkg.sv
// Shared constants, types and read-FSM states for the power-spectrum reader.
package mfcc_pkg;
  localparam int NBINS       = 257;
  localparam int POWER_WIDTH = 32;
  localparam int PTR_WIDTH   = 9;

  typedef logic [POWER_WIDTH-1:0] power_t;
  typedef logic [PTR_WIDTH-1:0]   bin_idx_t;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_VALID} rd_state_t;
endpackage

// File: rtl/spectrum_bank_ram.sv
// Two-bank 1W1R synchronous RAM; one frame of bins per bank, 1-cycle registered read.
module spectrum_bank_ram #(
  parameter int NBINS = 257,
  parameter int W     = 32,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  localparam int DEPTH = 2 * NBINS;
  localparam int IW    = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [IW-1:0] widx, ridx;

  // Bank 1 sits directly above bank 0 so the array is exactly 2*NBINS deep.
  assign widx = wbank ? IW'(NBINS) + IW'(waddr) : IW'(waddr);
  assign ridx = rbank ? IW'(NBINS) + IW'(raddr) : IW'(raddr);

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end
endmodule

// File: rtl/power_spectrum_reader.sv
// Captures FFT power frames into a ping-pong buffer and streams bins 0..NBINS-1 over valid/ready.
module power_spectrum_reader #(
  parameter int NBINS       = mfcc_pkg::NBINS,
  parameter int POWER_WIDTH = mfcc_pkg::POWER_WIDTH,
  parameter int PTR_WIDTH   = mfcc_pkg::PTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   power_valid_i,
  input  logic [PTR_WIDTH-1:0]   power_ptr_i,
  input  logic [POWER_WIDTH-1:0] power_sample_i,
  input  logic                   fft_done_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [POWER_WIDTH-1:0] out_data_o,
  output logic [PTR_WIDTH-1:0]   out_bin_o,
  output logic                   out_last_o,
  output logic                   frame_start_o,
  output logic                   overflow_o,
  output logic                   busy_o
);
  import mfcc_pkg::*;

  rd_state_t              state, state_nxt;
  logic [1:0]             full, full_nxt;
  logic                   wr_bank, rd_bank;
  logic [PTR_WIDTH-1:0]   rd_addr;
  logic [POWER_WIDTH-1:0] rdata;
  logic                   wr_en, ram_re, accept, is_last, release_bank, free_other;

  assign wr_en        = power_valid_i && (power_ptr_i < PTR_WIDTH'(NBINS));
  assign out_valid_o  = (state == R_VALID);
  assign accept       = out_valid_o && out_ready_i;
  assign is_last      = (rd_addr == PTR_WIDTH'(NBINS - 1));
  assign release_bank = accept && is_last;
  // A bank released by the reader on the same cycle counts as free.
  assign free_other   = !full[!wr_bank] || (release_bank && (rd_bank == !wr_bank));

  assign out_data_o = out_valid_o ? rdata : '0;
  assign out_bin_o  = rd_addr;
  assign out_last_o = out_valid_o && is_last;

  spectrum_bank_ram #(.NBINS(NBINS), .W(POWER_WIDTH), .AW(PTR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .wbank (wr_bank),
    .waddr (power_ptr_i),
    .wdata (power_sample_i),
    .re    (ram_re),
    .rbank (rd_bank),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  always_comb begin
    state_nxt = state;
    ram_re    = 1'b0;
    full_nxt  = full;
    case (state)
      R_IDLE:  if (full[rd_bank]) state_nxt = R_ADDR;
      R_ADDR:  begin
        ram_re    = 1'b1;
        state_nxt = R_VALID;
      end
      R_VALID: if (accept) state_nxt = is_last ? R_IDLE : R_ADDR;
      default: state_nxt = R_IDLE;
    endcase
    if (release_bank) full_nxt[rd_bank] = 1'b0;
    if (fft_done_i && free_other) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= R_IDLE;
      full          <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      rd_addr       <= '0;
      frame_start_o <= 1'b0;
      overflow_o    <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state         <= state_nxt;
      full          <= full_nxt;
      overflow_o    <= fft_done_i && !free_other;
      frame_start_o <= (state == R_ADDR) && (rd_addr == '0);
      busy_o        <= (|full) || (state != R_IDLE);
      if (fft_done_i && free_other) wr_bank <= !wr_bank;
      if (release_bank) rd_bank <= !rd_bank;
      if (accept) rd_addr <= is_last ? '0 : rd_addr + 1'b1;
    end
  end
endmodule

// File: tb/tb_power_spectrum_reader.sv
// Directed bench for power_spectrum_reader: frame streaming, stalls, drops, overflow, reset.
module tb_power_spectrum_reader;
  localparam int NB = 257;

  logic        clk = 1'b0;
  logic        rst;
  logic        power_valid_i;
  logic [8:0]  power_ptr_i;
  logic [31:0] power_sample_i;
  logic        fft_done_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [8:0]  out_bin_o;
  logic        out_last_o;
  logic        frame_start_o;
  logic        overflow_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int ovf_cnt = 0;

  power_spectrum_reader dut (
    .clk            (clk),
    .rst            (rst),
    .power_valid_i  (power_valid_i),
    .power_ptr_i    (power_ptr_i),
    .power_sample_i (power_sample_i),
    .fft_done_i     (fft_done_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_bin_o      (out_bin_o),
    .out_last_o     (out_last_o),
    .frame_start_o  (frame_start_o),
    .overflow_o     (overflow_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start_o === 1'b1) fs_cnt++;
    if (overflow_o === 1'b1) ovf_cnt++;
  end

  function automatic logic [31:0] pat(input int k, input int mul, input int off);
    return 32'(k * mul + off);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input int mul, input int off, input bit oob);
    for (int k = 0; k < NB; k++) begin
      power_valid_i  = 1'b1;
      power_ptr_i    = 9'(k);
      power_sample_i = pat(k, mul, off);
      step();
      if (oob && k < 255) begin
        power_ptr_i    = 9'(257 + k);
        power_sample_i = 32'hDEAD_BEEF;
        step();
      end
    end
    power_valid_i = 1'b0;
  endtask

  task automatic pulse_done();
    fft_done_i = 1'b1;
    step();
    fft_done_i = 1'b0;
  endtask

  // Accepts bins first..first+count-1 with ready asserted pct% of cycles.
  task automatic receive(input int mul, input int off, input int pct, input int first, input int count);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] hd = '0;
    logic [8:0]  hb = '0;
    while (got < count && cyc < count * 40 + 100) begin
      out_ready_i = ($urandom_range(99) < pct);
      if (stalled) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== hd || out_bin_o !== hb) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h bin=%0d required valid=1 data=%h bin=%0d",
                   out_valid_o, out_data_o, out_bin_o, hd, hb);
        end
      end
      if (frame_start_o === 1'b1) begin
        checks++;
        if (out_bin_o !== 9'd0 || out_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL frame_start_bin: bin=%0d valid=%b required bin=0 valid=1", out_bin_o, out_valid_o);
        end
      end
      if (out_valid_o === 1'b1) begin
        if (out_ready_i) begin
          checks++;
          if (out_data_o !== pat(first + got, mul, off) || out_bin_o !== 9'(first + got) ||
              out_last_o !== (first + got == NB - 1)) begin
            errors++;
            $display("FAIL bin_out: data=%h bin=%0d last=%b required data=%h bin=%0d last=%b",
                     out_data_o, out_bin_o, out_last_o, pat(first + got, mul, off), first + got,
                     (first + got == NB - 1));
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = out_data_o;
          hb = out_bin_o;
        end
      end else begin
        stalled = 1'b0;
        if (out_last_o !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL last_without_valid: last=%b required 0", out_last_o);
        end
      end
      step();
      cyc++;
    end
    out_ready_i = 1'b0;
    checks++;
    if (got != count) begin
      errors++;
      $display("FAIL receive_timeout: got %0d bins required %0d", got, count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({out_valid_o, out_last_o, frame_start_o, overflow_o, busy_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: valid/last/fs/ovf/busy=%b required 00000",
               {out_valid_o, out_last_o, frame_start_o, overflow_o, busy_o});
    end
    checks++;
    if (out_data_o !== 32'd0 || out_bin_o !== 9'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h bin=%0d required 0 0", out_data_o, out_bin_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    int fs0;
    fs0 = fs_cnt;
    write_frame(3, 0, 1'b0);
    pulse_done();
    checks++;
    if (out_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_c0: valid=%b ovf=%b required 0 0", out_valid_o, overflow_o);
    end
    step();
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_c1: valid=%b required 0", out_valid_o);
    end
    step();
    checks++;
    if (out_valid_o !== 1'b1 || frame_start_o !== 1'b1 || out_bin_o !== 9'd0) begin
      errors++;
      $display("FAIL latency_c2: valid=%b fs=%b bin=%0d required 1 1 0", out_valid_o, frame_start_o, out_bin_o);
    end
    receive(3, 0, 100, 0, NB);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_last_1: busy=%b required 1", busy_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_last_2: busy=%b required 0", busy_o);
    end
    checks++;
    if (fs_cnt - fs0 != 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d required 1", fs_cnt - fs0);
    end
  endtask

  task automatic test_oob();
    write_frame(5, 1, 1'b1);
    pulse_done();
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL oob_ovf_first: ovf=%b required 0", overflow_o);
    end
    // Second frame lands in the other bank while the first is still unread.
    write_frame(7, 2, 1'b1);
    pulse_done();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL oob_ovf_second: ovf=%b required 1", overflow_o);
    end
    receive(5, 1, 100, 0, NB);
    repeat (4) step();
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL oob_idle: valid=%b busy=%b required 0 0", out_valid_o, busy_o);
    end
  endtask

  task automatic test_stall();
    write_frame(3, 0, 1'b0);
    pulse_done();
    receive(3, 0, 30, 0, NB);
  endtask

  task automatic test_overflow();
    int ov0;
    ov0 = ovf_cnt;
    write_frame(11, 4, 1'b0);
    pulse_done();
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_a: ovf=%b required 0", overflow_o);
    end
    write_frame(17, 6, 1'b0);
    pulse_done();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_b: ovf=%b required 1", overflow_o);
    end
    write_frame(13, 9, 1'b0);
    pulse_done();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_c: ovf=%b required 1", overflow_o);
    end
    receive(11, 4, 100, 0, NB);
    repeat (6) step();
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || ovf_cnt - ov0 != 2) begin
      errors++;
      $display("FAIL ovf_after: valid=%b busy=%b ovf_pulses=%0d required 0 0 2",
               out_valid_o, busy_o, ovf_cnt - ov0);
    end
  endtask

  task automatic test_release_done();
    int ov0;
    int w;
    ov0 = ovf_cnt;
    write_frame(2, 0, 1'b0);
    pulse_done();
    write_frame(4, 3, 1'b0);
    receive(2, 0, 100, 0, NB - 1);
    w = 0;
    while (out_valid_o !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    checks++;
    if (out_valid_o !== 1'b1 || out_last_o !== 1'b1 || out_bin_o !== 9'(NB - 1)) begin
      errors++;
      $display("FAIL rel_last: valid=%b last=%b bin=%0d required 1 1 %0d", out_valid_o, out_last_o, out_bin_o, NB - 1);
    end
    out_ready_i = 1'b1;
    fft_done_i  = 1'b1;
    step();
    out_ready_i = 1'b0;
    fft_done_i  = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL rel_no_ovf: ovf=%b required 0", overflow_o);
    end
    receive(4, 3, 100, 0, NB);
    write_frame(6, 1, 1'b0);
    pulse_done();
    receive(6, 1, 100, 0, NB);
    checks++;
    if (ovf_cnt != ov0) begin
      errors++;
      $display("FAIL rel_ovf_count: got %0d pulses required 0", ovf_cnt - ov0);
    end
  endtask

  task automatic test_reset_mid();
    int fs0;
    write_frame(3, 0, 1'b0);
    pulse_done();
    receive(3, 0, 100, 0, 100);
    step();
    checks++;
    if (out_valid_o !== 1'b1 || out_bin_o !== 9'd100) begin
      errors++;
      $display("FAIL mid_bin100: valid=%b bin=%0d required 1 100", out_valid_o, out_bin_o);
    end
    rst = 1'b1;
    step();
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b required 0 0", out_valid_o, busy_o);
    end
    rst = 1'b0;
    step();
    fs0 = fs_cnt;
    write_frame(9, 5, 1'b0);
    pulse_done();
    receive(9, 5, 100, 0, NB);
    checks++;
    if (fs_cnt - fs0 != 1) begin
      errors++;
      $display("FAIL mid_frame_start: got %0d required 1", fs_cnt - fs0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    power_valid_i  = 1'b0;
    power_ptr_i    = '0;
    power_sample_i = '0;
    fft_done_i     = 1'b0;
    out_ready_i    = 1'b0;
    test_reset();
    test_stream();
    test_oob();
    test_stall();
    test_overflow();
    test_release_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
